pipeline_hazard_ctrl: RTL and testbench

Central control block that drives the `load` and flush controls of every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) in the 5-stage RISC-V core. It is the producer side of the loadable, resettable register interface.
- Freezes the whole pipeline while the shared memory is busy.
- Squashes wrong-path instructions on a taken branch.
- Inserts a bubble on a load-use hazard.
- Keeps saturating stall/flush counters and a sticky memory-timeout flag.

---
 rtl/pipeline_ctrl_pkg.sv | 31 +++
 rtl/hazard_detect.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and reset defaults for the pipeline hazard controller.
// Load/flush bundles are packed so the top can assign them as a unit.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } loads_t;

  typedef struct packed {
    logic ifid;
    logic idex;
    logic exmem;
  } flush_t;

  localparam loads_t RST_LOADS = '0;
  localparam flush_t RST_FLUSH = '1;
  localparam loads_t ALL_LOADS = '1;
  localparam flush_t NO_FLUSH  = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: the ID instruction reads a register
// that the load currently in ID/EX has not yet produced. x0 never hazards.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  lu_hazard
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit   = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit   = id_uses_rs2 && (id_rs2 == ex_rd);
    lu_hazard = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Drives load/flush enables of all five pipeline registers with priority
// freeze > branch flush > load-use > run; keeps stall/flush counters and a timeout flag.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             idex_load,
  output logic             exmem_load,
  output logic             memwb_load,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);

  import pipeline_ctrl_pkg::*;

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  logic   lu_hazard;
  logic   freeze;
  logic   br_sel;
  loads_t loads;
  flush_t flush;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              mem_err_q, mem_err_d;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .lu_hazard   (lu_hazard)
  );

  assign freeze = mem_req && !mem_ready;

  // Reset overrides combinationally so registers see the bubble state at once.
  always_comb begin
    loads  = ALL_LOADS;
    flush  = NO_FLUSH;
    br_sel = 1'b0;
    if (rst) begin
      loads = RST_LOADS;
      flush = RST_FLUSH;
    end else if (freeze) begin
      loads = '0;
    end else if (br_taken) begin
      flush  = '1;
      br_sel = 1'b1;
    end else if (lu_hazard) begin
      loads.pc   = 1'b0;
      loads.ifid = 1'b0;
      flush.idex = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (freeze) begin
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!loads.pc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (br_sel && (flush_cnt_q != '1))    flush_cnt_d = flush_cnt_q + 1'b1;
    // Report-only: the pipeline keeps waiting on memory after the flag sets.
    mem_err_d = mem_err_q || (freeze && (wait_cnt_d >= TIMEOUT_V));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign pc_load     = loads.pc;
  assign ifid_load   = loads.ifid;
  assign idex_load   = loads.idex;
  assign exmem_load  = loads.exmem;
  assign memwb_load  = loads.memwb;
  assign ifid_flush  = flush.ifid;
  assign idex_flush  = flush.idex;
  assign exmem_flush = flush.exmem;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with small counters and a short timeout.
// Control vector order: pc, ifid, idex, exmem, memwb loads, then ifid, idex, exmem flushes.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W       = 3;
  localparam int MEM_TIMEOUT = 8;

  localparam logic [7:0] C_RST    = 8'b00000_111;
  localparam logic [7:0] C_RUN    = 8'b11111_000;
  localparam logic [7:0] C_FREEZE = 8'b00000_000;
  localparam logic [7:0] C_BRANCH = 8'b11111_111;
  localparam logic [7:0] C_LU     = 8'b00111_010;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_mem_read;
  logic             br_taken, mem_req, mem_ready;
  logic             pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic             ifid_flush, idex_flush, exmem_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_err;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
    .exmem_load(exmem_load), .memwb_load(memwb_load),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_vec();
    return {24'd0, pc_load, ifid_load, idex_load, exmem_load, memwb_load,
            ifid_flush, idex_flush, exmem_flush};
  endfunction

  function automatic int sat(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_ctrl(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, ctrl_vec(), {24'd0, exp});
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_stall"}, 32'(stall_cnt), 32'(sat(exp_stall)));
    chk({tag, "_flush"}, 32'(flush_cnt), 32'(sat(exp_flush)));
  endtask

  initial begin
    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

    // reset state
    tick();
    chk_ctrl("rst_ctrl", C_RST);
    chk_cnts("rst");
    chk("rst_err", 32'(mem_err), 32'd0);
    rst = 1'b0;
    chk_ctrl("run_idle", C_RUN);

    // x0 destination never hazards
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    chk_ctrl("x0_ctrl", C_RUN);
    tick();
    chk_cnts("x0");

    // unused rs2 match is not a hazard
    ex_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd3; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    chk_ctrl("rs2_unused_ctrl", C_RUN);
    tick();
    chk_cnts("rs2_unused");

    // rs2 used: load-use stall, bubble releases it
    id_uses_rs2 = 1'b1;
    chk_ctrl("rs2_lu_ctrl", C_LU);
    tick(); exp_stall++;
    chk_cnts("rs2_lu");
    ex_mem_read = 1'b0;
    chk_ctrl("rs2_release", C_RUN);
    tick();

    // rs1 load-use
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0;
    chk_ctrl("rs1_lu_ctrl", C_LU);
    tick(); exp_stall++;
    chk_cnts("rs1_lu");
    ex_mem_read = 1'b0;
    chk_ctrl("rs1_release", C_RUN);
    tick();
    chk_cnts("rs1_after");

    // branch overrides a simultaneous load-use
    ex_mem_read = 1'b1; br_taken = 1'b1;
    chk_ctrl("br_ctrl", C_BRANCH);
    tick(); exp_flush++;
    chk_cnts("br");
    br_taken = 1'b0; ex_mem_read = 1'b0;
    chk_ctrl("br_end", C_RUN);
    tick();
    chk_cnts("br_after");

    // freeze with a pending branch, then flush on mem_ready
    mem_req = 1'b1; mem_ready = 1'b0; br_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_ctrl($sformatf("frz_ctrl%0d", i), C_FREEZE);
      tick(); exp_stall++;
    end
    mem_ready = 1'b1;
    chk_ctrl("frz_release_br", C_BRANCH);
    tick(); exp_flush++;
    chk_cnts("frz");
    chk("frz_err", 32'(mem_err), 32'd0);
    mem_req = 1'b0; mem_ready = 1'b0; br_taken = 1'b0;
    chk_ctrl("frz_run", C_RUN);
    tick();

    // timeout after 8 wait cycles; stall counter saturates
    mem_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(); exp_stall++;
      if (i == 7) chk("tmo_err_pre", 32'(mem_err), 32'd0);
      if (i == 8) chk("tmo_err_set", 32'(mem_err), 32'd1);
    end
    chk_cnts("tmo");
    mem_ready = 1'b1;
    chk_ctrl("tmo_ready_ctrl", C_RUN);
    tick();
    chk("tmo_err_ready", 32'(mem_err), 32'd1);
    mem_req = 1'b0; mem_ready = 1'b0;
    tick();
    chk("tmo_err_sticky", 32'(mem_err), 32'd1);

    // asynchronous reset in the middle of a freeze
    mem_req = 1'b1;
    tick(); tick();
    @(posedge clk);
    #2 rst = 1'b1;
    exp_stall = 0; exp_flush = 0;
    chk_ctrl("arst_ctrl", C_RST);
    chk_cnts("arst");
    chk("arst_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_req = 1'b0;
    chk_ctrl("arst_run", C_RUN);
    tick();
    chk_cnts("arst_idle");

    // wait counter restarted from zero: 7 cycles do not time out
    mem_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(); exp_stall++;
    end
    chk("post_rst_err", 32'(mem_err), 32'd0);
    chk_cnts("post_rst");
    mem_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
